// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: EX/MEM register, data-bus master, load alignment
//
// Purpose: holds the EX/MEM pipeline register, issues data-memory transfers on a
// valid/ready bus, aligns/extends load data, and stalls the front of the pipe
// while a transfer waits. Misaligned accesses and bus timeouts are dropped with
// a one-cycle fault pulse and the rd write suppressed.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   flushM                      load a bubble into EX/MEM instead of the EX outputs
//   alu_outE, dm_wdE, rdE       EX address/result, store data, destination register
//   reg_writeE, mem_readE,
//   mem_writeE, funct3E         EX control and access size/sign
//   resultM, rdM                registered ALU result (forwarding line), registered rd
//   reg_writeM, mem_to_regM     rd write enable (dropped on fault), WB load select
//   ld_dataM                    aligned/extended load data, nonzero only on the ready cycle
//   mem_stall                   freeze IF/ID/EX and EX/MEM
//   misalign_fault, bus_fault   one-cycle fault pulses
//   dbus_req, dbus_we,
//   dbus_addr, dbus_be,
//   dbus_wdata                  data-bus request, write flag, word address, byte enables, data
//   dbus_ready, dbus_rdata      transfer complete this cycle, read word

module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushM,
  input  logic [31:0] alu_outE,
  input  logic [31:0] dm_wdE,
  input  logic [4:0]  rdE,
  input  logic        reg_writeE,
  input  logic        mem_readE,
  input  logic        mem_writeE,
  input  logic [2:0]  funct3E,
  output logic [31:0] resultM,
  output logic [4:0]  rdM,
  output logic        reg_writeM,
  output logic        mem_to_regM,
  output logic [31:0] ld_dataM,
  output logic        mem_stall,
  output logic        misalign_fault,
  output logic        bus_fault,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ready,
  input  logic [31:0] dbus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        valid_q, valid_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] wd_q, wd_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        memop, mis, timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // EX/MEM capture: frozen while stalled, so a flush during a stall is ignored.
  always_comb begin
    valid_d     = valid_q;
    alu_out_d   = alu_out_q;
    wd_d        = wd_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    funct3_d    = funct3_q;
    if (!mem_stall) begin
      valid_d     = ~flushM;
      alu_out_d   = alu_outE;
      wd_d        = dm_wdE;
      rd_d        = rdE;
      reg_write_d = reg_writeE & ~flushM;
      mem_read_d  = mem_readE & ~flushM;
      mem_write_d = mem_writeE & ~flushM;
      funct3_d    = funct3E;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      alu_out_q   <= '0;
      wd_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      funct3_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      alu_out_q   <= alu_out_d;
      wd_q        <= wd_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      funct3_q    <= funct3_d;
    end
  end

  assign memop = valid_q & (mem_read_q | mem_write_q);
  assign mis   = ((funct3_q[1:0] == 2'b10) && (alu_out_q[1:0] != 2'b00)) ||
                 ((funct3_q[1:0] == 2'b01) && alu_out_q[0]);

  // Issue happens in IDLE with zero latency; WAIT keeps the request up while the
  // register is frozen, so address/data stay stable without extra holding regs.
  assign dbus_req = (state_q == S_WAIT) | (memop & ~mis);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dbus_req && !dbus_ready) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (dbus_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_stall      = dbus_req & ~dbus_ready & ~timeout;
  assign misalign_fault = memop & mis;
  assign bus_fault      = timeout;
  assign reg_writeM     = reg_write_q & ~misalign_fault & ~timeout;
  assign mem_to_regM    = valid_q & mem_read_q;
  assign resultM        = alu_out_q;
  assign rdM            = rd_q;

  assign dbus_we   = dbus_req & mem_write_q;
  assign dbus_addr = dbus_req ? {alu_out_q[31:2], 2'b00} : 32'd0;

  always_comb begin
    dbus_be    = 4'b0000;
    dbus_wdata = 32'd0;
    if (dbus_req) begin
      case (funct3_q[1:0])
        2'b00: begin
          dbus_be    = 4'b0001 << alu_out_q[1:0];
          dbus_wdata = {4{wd_q[7:0]}};
        end
        2'b01: begin
          dbus_be    = 4'b0011 << alu_out_q[1:0];
          dbus_wdata = {2{wd_q[15:0]}};
        end
        default: begin
          dbus_be    = 4'b1111;
          dbus_wdata = wd_q;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dbus_rdata[7:0];
    case (alu_out_q[1:0])
      2'b01:   ld_byte = dbus_rdata[15:8];
      2'b10:   ld_byte = dbus_rdata[23:16];
      2'b11:   ld_byte = dbus_rdata[31:24];
      default: ld_byte = dbus_rdata[7:0];
    endcase
    ld_half = alu_out_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dbus_rdata;
    endcase
  end

  // Only a completing read produces load data; everything else reads as zero.
  assign ld_dataM = (dbus_req & dbus_ready & ~dbus_we & mem_read_q) ? ld_ext : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage

module tb_mem_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushM;
  logic [31:0] alu_outE, dm_wdE;
  logic [4:0]  rdE;
  logic        reg_writeE, mem_readE, mem_writeE;
  logic [2:0]  funct3E;
  logic [31:0] resultM;
  logic [4:0]  rdM;
  logic        reg_writeM, mem_to_regM;
  logic [31:0] ld_dataM;
  logic        mem_stall, misalign_fault, bus_fault;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ready;
  logic [31:0] dbus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .flushM(flushM),
    .alu_outE(alu_outE), .dm_wdE(dm_wdE), .rdE(rdE),
    .reg_writeE(reg_writeE), .mem_readE(mem_readE), .mem_writeE(mem_writeE),
    .funct3E(funct3E),
    .resultM(resultM), .rdM(rdM), .reg_writeM(reg_writeM), .mem_to_regM(mem_to_regM),
    .ld_dataM(ld_dataM), .mem_stall(mem_stall),
    .misalign_fault(misalign_fault), .bus_fault(bus_fault),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata)
  );

  typedef struct {
    logic        flush;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    int          lat;
  } txn_t;

  txn_t txq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic flush, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input int lat);
    txn_t t;
    t.flush = flush; t.f3 = f3; t.addr = addr; t.wd = wd; t.rdata = rdata;
    t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw; t.lat = lat;
    return t;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  task automatic drive_e(input txn_t t);
    flushM     = t.flush;
    funct3E    = t.f3;
    alu_outE   = t.addr;
    dm_wdE     = t.wd;
    rdE        = t.rd;
    reg_writeE = t.rw;
    mem_readE  = t.mr;
    mem_writeE = t.mw;
  endtask

  task automatic drive_garbage();
    flushM     = 1'($urandom);
    funct3E    = 3'($urandom);
    alu_outE   = $urandom;
    dm_wdE     = $urandom;
    rdE        = 5'($urandom);
    reg_writeE = 1'($urandom);
    mem_readE  = 1'($urandom);
    mem_writeE = 1'($urandom);
  endtask

  function automatic txn_t nop();
    return mk(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  // Each queued instruction is followed through its stay in MEM; expectations come
  // from the instruction fields and its chosen bus latency alone.
  task automatic run_queue();
    txn_t t;
    logic valid, memop, mis, req, last, rdy, tmo, stall;
    int   last_k;
    drive_e(txq[0]);
    @(posedge clk);
    for (int i = 0; i < txq.size(); i++) begin
      t      = txq[i];
      valid  = !t.flush;
      memop  = valid && (t.mr || t.mw);
      mis    = memop && (((t.f3[1:0] == 2'b10) && (t.addr[1:0] != 2'b00)) ||
                         ((t.f3[1:0] == 2'b01) && t.addr[0]));
      req    = memop && !mis;
      last_k = !req ? 0 : ((t.lat <= TMO) ? t.lat : TMO);
      for (int k = 0; k <= last_k; k++) begin
        @(negedge clk);
        rdy        = req && (k == t.lat);
        dbus_ready = req ? rdy : 1'($urandom);
        dbus_rdata = rdy ? t.rdata : $urandom;
        #1;
        tmo   = req && (k == TMO) && (t.lat > TMO);
        stall = req && (k < last_k);
        last  = (k == last_k);
        chk("req", dbus_req, req);
        chk("stall", mem_stall, stall);
        chk("bus_fault", bus_fault, tmo);
        chk("misalign", misalign_fault, mis);
        chk("reg_writeM", reg_writeM, valid && t.rw && !mis && !tmo);
        chk("mem_to_regM", mem_to_regM, valid && t.mr);
        chk("resultM", resultM, t.addr);
        chk("rdM", rdM, t.rd);
        chk("ld_dataM", ld_dataM, (rdy && t.mr) ? ld_model(t.f3, t.addr, t.rdata) : 32'd0);
        if (req) begin
          chk("we", dbus_we, t.mw);
          chk("addr", dbus_addr, t.addr & 32'hFFFF_FFFC);
          if (t.mw) begin
            chk("be", dbus_be, (t.f3[1:0] == 2'b00) ? (32'd1 << t.addr[1:0]) :
                               (t.f3[1:0] == 2'b01) ? (32'd3 << t.addr[1:0]) : 32'hF);
            chk("wdata", dbus_wdata, (t.f3[1:0] == 2'b00) ? (t.wd & 32'hFF) * 32'h0101_0101 :
                                     (t.f3[1:0] == 2'b01) ? (t.wd & 32'hFFFF) * 32'h0001_0001 : t.wd);
          end
        end
        if (last) drive_e((i + 1 < txq.size()) ? txq[i + 1] : nop());
        else      drive_garbage();
        @(posedge clk);
      end
    end
    txq.delete();
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int   kind, lsel;
    logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    kind    = $urandom_range(0, 2);
    t       = nop();
    t.flush = ($urandom_range(0, 7) == 0);
    t.addr  = $urandom;
    if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
    t.wd    = $urandom;
    t.rdata = $urandom;
    t.rd    = 5'($urandom);
    lsel    = $urandom_range(0, 9);
    t.lat   = (lsel < 6) ? $urandom_range(0, 4) : (lsel == 6) ? TMO - 1 :
              (lsel == 7) ? TMO : (lsel == 8) ? TMO + 5 : $urandom_range(5, 12);
    case (kind)
      0: begin t.f3 = 3'($urandom); t.rw = 1'($urandom); end
      1: begin t.f3 = ldf[$urandom_range(0, 4)]; t.mr = 1'b1; t.rw = 1'b1; end
      default: begin t.f3 = 3'($urandom_range(0, 2)); t.mw = 1'b1; end
    endcase
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    drive_e(nop());
    dbus_ready = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    #12;
    chk("rst_req", dbus_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_result", resultM, 32'd0);
    chk("rst_ld", ld_dataM, 32'd0);
    chk("rst_rw", reg_writeM, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, then random traffic.
    txq.push_back(mk(1'b0, 3'd0, 32'h1003, 32'hAB, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 0));
    txq.push_back(mk(1'b0, 3'd1, 32'h2002, 32'd0, 32'h8001_1234, 5'd5, 1'b1, 1'b1, 1'b0, 3));
    txq.push_back(mk(1'b0, 3'd5, 32'h2002, 32'd0, 32'h8001_1234, 5'd6, 1'b1, 1'b1, 1'b0, 3));
    txq.push_back(mk(1'b0, 3'd2, 32'h2001, 32'd0, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 0));
    txq.push_back(mk(1'b0, 3'd2, 32'h3000, 32'h1234_5678, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 100));
    txq.push_back(mk(1'b1, 3'd2, 32'h4000, 32'd0, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 0));
    txq.push_back(mk(1'b0, 3'd2, 32'h4004, 32'd0, 32'h0BAD_F00D, 5'd10, 1'b1, 1'b1, 1'b0, TMO));
    for (int n = 0; n < 80; n++) txq.push_back(rand_txn());
    run_queue();

    // Reset while a load is stuck waiting.
    drive_e(mk(1'b0, 3'd2, 32'h5000, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 100));
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dbus_ready = 1'b0;
    end
    drive_e(nop());
    #1;
    chk("pre_rst_stall", mem_stall, 1'b1);
    rst        = 1'b1;
    dbus_ready = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("arst_req", dbus_req, 1'b0);
    chk("arst_stall", mem_stall, 1'b0);
    chk("arst_ld", ld_dataM, 32'd0);
    chk("arst_result", resultM, 32'd0);
    chk("arst_mtr", mem_to_regM, 1'b0);
    @(negedge clk);
    #2;
    rst        = 1'b0;
    dbus_ready = 1'b0;
    #1;
    chk("post_rst_req", dbus_req, 1'b0);
    chk("post_rst_stall", mem_stall, 1'b0);

    txq.push_back(mk(1'b0, 3'd0, 32'h6001, 32'd0, 32'h0000_8000, 5'd4, 1'b1, 1'b1, 1'b0, 2));
    txq.push_back(mk(1'b0, 3'd1, 32'h6006, 32'hCAFE, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1));
    for (int n = 0; n < 20; n++) txq.push_back(rand_txn());
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
